// File: rtl/wb_timer.sv
// Wishbone slave timer: 32-bit up-counter with prescaler, compare match,
// one-shot/auto-reload modes and a level interrupt.
module wb_timer #(
    parameter int unsigned PrescaleWidth = 16
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_adr,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_dat,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_dat,
    output logic        irq_out
);

    localparam logic [2:0] AddrCtrl     = 3'd0;
    localparam logic [2:0] AddrPrescale = 3'd1;
    localparam logic [2:0] AddrCount    = 3'd2;
    localparam logic [2:0] AddrCompare  = 3'd3;
    localparam logic [2:0] AddrStatus   = 3'd4;

    // r_ctrl: bit0 enable, bit1 auto_reload, bit2 irq_en
    logic [2:0]               r_ctrl;
    logic [PrescaleWidth-1:0] r_prescale;
    logic [PrescaleWidth-1:0] r_pcnt;
    logic [31:0]              r_count;
    logic [31:0]              r_compare;
    logic                     r_match;
    logic                     r_ack;
    logic [31:0]              r_rdata;

    logic        w_req;
    logic        w_wr;
    logic        w_rd;
    logic [2:0]  w_addr;
    logic        w_wr_ctrl;
    logic        w_wr_prescale;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_clear;
    logic        w_tick;
    logic        w_hit;
    logic [31:0] w_reg_val;
    logic [31:0] w_merged;
    logic        w_unused_adr;

    assign w_addr       = i_wb_adr[4:2];
    assign w_unused_adr = ^{i_wb_adr[31:5], i_wb_adr[1:0]};

    assign w_req = i_wb_cyc & i_wb_stb & ~r_ack;
    assign w_wr  = w_req & i_wb_we;
    assign w_rd  = w_req & ~i_wb_we;

    assign w_wr_ctrl     = w_wr && (w_addr == AddrCtrl);
    assign w_wr_prescale = w_wr && (w_addr == AddrPrescale);
    assign w_wr_count    = w_wr && (w_addr == AddrCount);
    assign w_wr_compare  = w_wr && (w_addr == AddrCompare);
    assign w_clear       = w_wr && (w_addr == AddrStatus) && i_wb_sel[0] && i_wb_dat[0];

    assign w_tick = r_ctrl[0] && (r_pcnt == r_prescale);
    assign w_hit  = (r_count == r_compare);

    always_comb begin
        w_reg_val = '0;
        case (w_addr)
            AddrCtrl:     w_reg_val = {29'd0, r_ctrl};
            AddrPrescale: w_reg_val = 32'(r_prescale);
            AddrCount:    w_reg_val = r_count;
            AddrCompare:  w_reg_val = r_compare;
            AddrStatus:   w_reg_val = {31'd0, r_match};
            default:      w_reg_val = '0;
        endcase
    end

    // Byte-lane merge of the write data over the addressed register's current value
    always_comb begin
        w_merged = w_reg_val;
        for (int i = 0; i < 4; i++) begin
            if (i_wb_sel[i]) begin
                w_merged[i*8 +: 8] = i_wb_dat[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_ctrl     <= '0;
            r_prescale <= '0;
            r_pcnt     <= '0;
            r_count    <= '0;
            r_compare  <= 32'hFFFF_FFFF;
            r_match    <= 1'b0;
            r_ack      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_ack   <= w_req;
            r_rdata <= w_rd ? w_reg_val : 32'd0;

            // Bus writes take priority over the tick's own updates
            if (w_wr_ctrl) begin
                r_ctrl <= w_merged[2:0];
            end else if (w_tick && w_hit && !r_ctrl[1]) begin
                r_ctrl[0] <= 1'b0;
            end

            if (w_wr_prescale) begin
                r_prescale <= w_merged[PrescaleWidth-1:0];
            end

            if (w_wr_ctrl || w_wr_prescale || !r_ctrl[0] || w_tick) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + 1'b1;
            end

            if (w_wr_count) begin
                r_count <= w_merged;
            end else if (w_tick) begin
                if (!w_hit) begin
                    r_count <= r_count + 32'd1;
                end else if (r_ctrl[1]) begin
                    r_count <= '0;
                end
            end

            if (w_wr_compare) begin
                r_compare <= w_merged;
            end

            if (w_tick && w_hit) begin
                r_match <= 1'b1;
            end else if (w_clear) begin
                r_match <= 1'b0;
            end
        end
    end

    assign o_wb_ack = r_ack;
    assign o_wb_dat = r_rdata;
    assign irq_out  = r_match & r_ctrl[2];

endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: directed steps plus randomized runs checked
// against a tick-count model of the timer.
module tb_wb_timer;

    localparam logic [2:0] RCtrl = 3'd0, RPre = 3'd1, RCnt = 3'd2, RCmp = 3'd3, RSt = 3'd4;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        cyc, stb, we;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic        ack;
    logic [31:0] rdat;
    logic        irq;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    int unsigned edge_n   = 0;
    int unsigned last_edge;
    logic [31:0] rd_q;

    // Current run configuration for the model
    logic [2:0]  m_mode;
    int unsigned m_p, m_c, m_e;

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    wb_timer #(.PrescaleWidth(16)) dut (
        .clk_in   (clk),
        .reset_in (reset_in),
        .i_wb_cyc (cyc),
        .i_wb_stb (stb),
        .i_wb_we  (we),
        .i_wb_adr (adr),
        .i_wb_sel (sel),
        .i_wb_dat (wdat),
        .o_wb_ack (ack),
        .o_wb_dat (rdat),
        .irq_out  (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One classic access; called at a negedge, returns at a negedge two cycles later
    task automatic bus(input logic w, input logic [2:0] idx, input logic [31:0] d,
                       input logic [3:0] s);
        cyc = 1'b1; stb = 1'b1; we = w; adr = {27'd0, idx, 2'b00}; wdat = d; sel = s;
        @(posedge clk);
        @(negedge clk);
        last_edge = edge_n;
        rd_q = rdat;
        check("ack_high", {31'd0, ack}, 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        check("ack_drop", {31'd0, ack}, 32'd0);
        check("rdat_idle", rdat, 32'd0);
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] d);
        bus(1'b1, idx, d, 4'hF);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] idx, input logic [31:0] exp);
        bus(1'b0, idx, 32'd0, 4'hF);
        check(tag, rd_q, exp);
    endtask

    task automatic wait_edge(input int unsigned n);
        while (edge_n < n) @(negedge clk);
    endtask

    // Ticks effective at or before edge 'upto' for a run enabled at edge e
    function automatic int unsigned ticks(input int unsigned upto);
        return (upto <= m_e) ? 0 : (upto - m_e) / (m_p + 1);
    endfunction

    function automatic logic [31:0] model(input logic [2:0] idx, input int unsigned upto);
        int unsigned t;
        logic hit;
        t   = ticks(upto);
        hit = (t > m_c);
        case (idx)
            RCtrl:   return {29'd0, (hit && !m_mode[1]) ? (m_mode & 3'b110) : m_mode};
            RPre:    return m_p;
            RCnt:    return m_mode[1] ? t % (m_c + 1) : (hit ? m_c : t);
            RCmp:    return m_c;
            RSt:     return {31'd0, hit};
            default: return 32'd0;
        endcase
    endfunction

    task automatic start_run(input logic [2:0] mode, input int unsigned p, input int unsigned c);
        wr(RCtrl, 32'd0);
        wr(RSt, 32'd1);
        wr(RCnt, 32'd0);
        wr(RPre, p);
        wr(RCmp, c);
        wr(RCtrl, {29'd0, mode});
        m_mode = mode; m_p = p; m_c = c; m_e = last_edge;
    endtask

    task automatic rd_model(input string tag, input logic [2:0] idx);
        bus(1'b0, idx, 32'd0, 4'hF);
        check(tag, rd_q, model(idx, last_edge - 1));
    endtask

    task automatic irq_model(input string tag);
        check(tag, {31'd0, irq}, {31'd0, m_mode[2] && (ticks(edge_n) > m_c)});
    endtask

    initial begin
        logic [31:0] cmp_v, d_v, exp_v;
        logic [3:0]  s_v;
        int unsigned e;

        // Reset, with a write to COMPARE pending across it
        reset_in = 1'b1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0C; wdat = 32'h1234; sel = 4'hF;
        repeat (2) @(negedge clk);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_rdat", rdat, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        reset_in = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        check("post_rst_ack", {31'd0, ack}, 32'd0);
        rd_chk("rst_ctrl", RCtrl, 32'd0);
        rd_chk("rst_pre", RPre, 32'd0);
        rd_chk("rst_cnt", RCnt, 32'd0);
        rd_chk("rst_cmp", RCmp, 32'hFFFF_FFFF);
        rd_chk("rst_st", RSt, 32'd0);

        // STB held high past the ACK: ACK still lasts one cycle
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0C;
        @(posedge clk);
        @(negedge clk);
        check("hold_ack", {31'd0, ack}, 32'd1);
        @(negedge clk);
        check("hold_ack_drop", {31'd0, ack}, 32'd0);
        cyc = 1'b0; stb = 1'b0;

        // STB without CYC: no access, no ACK
        stb = 1'b1; we = 1'b1; adr = 32'h0C; wdat = 32'd0;
        @(negedge clk);
        check("nocyc_ack", {31'd0, ack}, 32'd0);
        stb = 1'b0; we = 1'b0;
        @(negedge clk);
        rd_chk("nocyc_cmp", RCmp, 32'hFFFF_FFFF);

        // Byte lanes
        bus(1'b1, RCmp, 32'hAABB_CCDD, 4'b0101);
        rd_chk("sel_cmp", RCmp, 32'hFFBB_FFDD);

        // Auto-reload: P=3, C=2, irq_en
        start_run(3'b111, 3, 2);
        e = m_e;
        wait_edge(e + 11);
        irq_model("auto_irq_pre");
        check("auto_irq_lo", {31'd0, irq}, 32'd0);
        @(negedge clk);
        irq_model("auto_irq_rise");
        check("auto_irq_hi", {31'd0, irq}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            repeat (i) @(negedge clk);
            rd_model("auto_cnt", RCnt);
        end
        rd_model("auto_st", RSt);

        // One-shot: P=0, C=5
        start_run(3'b001, 0, 5);
        wait_edge(m_e + 3);
        rd_model("os_cnt_early", RCnt);
        rd_model("os_st_early", RSt);
        rd_model("os_st", RSt);
        rd_chk("os_st_set", RSt, 32'd1);
        rd_chk("os_ctrl", RCtrl, 32'd0);
        rd_chk("os_cnt", RCnt, 32'd5);
        repeat (5) @(negedge clk);
        rd_chk("os_cnt_hold", RCnt, 32'd5);

        // STATUS clear colliding with a match tick: set wins
        start_run(3'b011, 3, 0);
        e = m_e;
        wait_edge(e + 7);
        wr(RSt, 32'd1);
        rd_chk("coll_st", RSt, 32'd1);
        wait_edge(e + 13);
        bus(1'b1, RSt, 32'd1, 4'b1110);
        rd_chk("clr_nosel", RSt, 32'd1);
        wait_edge(e + 21);
        wr(RSt, 32'd1);
        rd_chk("clr_ok", RSt, 32'd0);

        // COUNT write colliding with a tick: write wins
        start_run(3'b011, 1, 32'hFFFF_FFFF);
        wait_edge(m_e + 3);
        wr(RCnt, 32'h10);
        rd_chk("coll_cnt", RCnt, 32'h10);

        // Wrap without a flag, then match on the next tick
        wr(RCtrl, 32'd0);
        wr(RSt, 32'd1);
        wr(RCnt, 32'hFFFF_FFFF);
        wr(RPre, 32'd7);
        wr(RCmp, 32'd0);
        wr(RCtrl, 32'd1);
        e = last_edge;
        wait_edge(e + 9);
        rd_chk("wrap_cnt", RCnt, 32'd0);
        rd_chk("wrap_st", RSt, 32'd0);
        wait_edge(e + 17);
        rd_chk("wrap_match", RSt, 32'd1);
        rd_chk("wrap_cnt_hold", RCnt, 32'd0);
        rd_chk("wrap_ctrl", RCtrl, 32'd0);

        // Unmapped offsets and PRESCALE width
        wr(3'd5, 32'hDEAD_BEEF);
        rd_chk("unmap_14", 3'd5, 32'd0);
        rd_chk("unmap_18", 3'd6, 32'd0);
        rd_chk("unmap_1c", 3'd7, 32'd0);
        wr(RPre, 32'hFFFF_FFFF);
        rd_chk("pre_width", RPre, 32'h0000_FFFF);

        // Randomized byte lanes and timer runs
        for (int it = 0; it < 6; it++) begin
            wr(RCtrl, 32'd0);
            cmp_v = $urandom;
            d_v   = $urandom;
            s_v   = 4'($urandom_range(0, 15));
            wr(RCmp, cmp_v);
            bus(1'b1, RCmp, d_v, s_v);
            for (int b = 0; b < 4; b++) begin
                exp_v[b*8 +: 8] = s_v[b] ? d_v[b*8 +: 8] : cmp_v[b*8 +: 8];
            end
            rd_chk("rnd_sel", RCmp, exp_v);

            start_run({1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1},
                      $urandom_range(0, 4), $urandom_range(0, 5));
            for (int j = 0; j < 6; j++) begin
                repeat ($urandom_range(0, 6)) @(negedge clk);
                irq_model("rnd_irq");
                rd_model("rnd_reg", 3'($urandom_range(0, 4)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
